// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the FD/DX/XM latches and PC: load-use bubbles, branch squash, mul/div freeze.
// Outputs are combinational from state and inputs; optional stall counter built under PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
  parameter logic [31:0] NOP_INSN = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] fd_insn,
  input  logic [31:0] dx_insn,
  input  logic        branch_taken,
  input  logic        md_ready,
  output logic        pc_en,
  output logic        fd_en,
  output logic        dx_en,
  output logic        xm_en,
  output logic        fd_flush,
  output logic        dx_flush,
  output logic        md_start,
  output logic [31:0] stall_cycles
);

  typedef enum logic {RUN, MD_WAIT} state_t;

  localparam logic [4:0] OP_ALU = 5'b00000;
  localparam logic [4:0] OP_LW  = 5'b01000;
  localparam logic [4:0] OP_SW  = 5'b00111;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  state_t state, state_nxt;
  logic   md_done, md_done_nxt;

  logic [4:0] fd_op, fd_rd, fd_rs, fd_rt;
  logic [4:0] dx_op, dx_rd, dx_alu;
  logic       dx_is_md, load_use;
  logic       unused_fd;

  assign fd_op  = fd_insn[31:27];
  assign fd_rd  = fd_insn[26:22];
  assign fd_rs  = fd_insn[21:17];
  assign fd_rt  = fd_insn[16:12];
  assign dx_op  = dx_insn[31:27];
  assign dx_rd  = dx_insn[26:22];
  assign dx_alu = dx_insn[6:2];
  assign unused_fd = ^fd_insn[11:0];

  // A bubble loaded as NOP_INSN never counts as a multdiv op.
  assign dx_is_md = (dx_op == OP_ALU) && ((dx_alu == ALU_MUL) || (dx_alu == ALU_DIV)) &&
                    (dx_insn != NOP_INSN);

  assign load_use = (dx_op == OP_LW) && (dx_rd != 5'd0) &&
                    ((fd_rs == dx_rd) ||
                     ((fd_op == OP_ALU) && (fd_rt == dx_rd)) ||
                     ((fd_op == OP_SW) && (fd_rd == dx_rd)));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= RUN;
      md_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      md_done <= md_done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    md_done_nxt = md_done;
    pc_en       = 1'b0;
    fd_en       = 1'b0;
    dx_en       = 1'b0;
    xm_en       = 1'b0;
    fd_flush    = 1'b0;
    dx_flush    = 1'b0;
    md_start    = 1'b0;
    if (reset) begin
      case (state)
        RUN: begin
          if (dx_is_md && !md_done) begin
            md_start  = 1'b1;
            state_nxt = MD_WAIT;
          end else begin
            {pc_en, fd_en, dx_en, xm_en} = 4'b1111;
            md_done_nxt = 1'b0;
            if (branch_taken) begin
              fd_flush = 1'b1;
              dx_flush = 1'b1;
            end else if (load_use) begin
              pc_en    = 1'b0;
              fd_en    = 1'b0;
              dx_flush = 1'b1;
            end
          end
        end
        MD_WAIT: begin
          if (md_ready) begin
            {pc_en, fd_en, dx_en, xm_en} = 4'b1111;
            state_nxt   = RUN;
            md_done_nxt = 1'b1;
            if (load_use) begin
              pc_en    = 1'b0;
              fd_en    = 1'b0;
              dx_flush = 1'b1;
            end
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt <= 32'h0;
    end else if (!pc_en) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed test-plan scenarios then random traffic against a rule-level model.
module tb_pipe_hazard_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] fd_insn = 32'h0;
  logic [31:0] dx_insn = 32'h0;
  logic        branch_taken = 1'b0;
  logic        md_ready = 1'b0;
  logic        pc_en, fd_en, dx_en, xm_en, fd_flush, dx_flush, md_start;
  logic [31:0] stall_cycles;

  pipe_hazard_ctrl dut (
    .clock(clock), .reset(reset), .fd_insn(fd_insn), .dx_insn(dx_insn),
    .branch_taken(branch_taken), .md_ready(md_ready), .pc_en(pc_en), .fd_en(fd_en),
    .dx_en(dx_en), .xm_en(xm_en), .fd_flush(fd_flush), .dx_flush(dx_flush),
    .md_start(md_start), .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // model state: waiting on multdiv, result-already-taken flag, stall count
  bit          m_wait = 1'b0;
  bit          m_done = 1'b0;
  logic [31:0] m_cnt = 32'h0;
  logic [6:0]  obs;
  logic [31:0] obs_stall;

  // {pc_en, fd_en, dx_en, xm_en, fd_flush, dx_flush, md_start}
  localparam logic [6:0] V_NORM   = 7'b1111000;
  localparam logic [6:0] V_LU     = 7'b0011010;
  localparam logic [6:0] V_BR     = 7'b1111110;
  localparam logic [6:0] V_START  = 7'b0000001;
  localparam logic [6:0] V_FROZEN = 7'b0000000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] alu);
    return {op, rd, rs, rt, 5'd0, alu, 2'b00};
  endfunction

  task automatic step(input string tag, input logic [31:0] fd, input logic [31:0] dx,
                      input logic br, input logic rdy);
    logic [4:0] dop, drd, dalu, fop, frd, frs, frt;
    logic       is_md, lu, freeze, squash, bubble;
    logic [6:0] exp;
    @(negedge clock);
    reset = 1'b1;
    fd_insn = fd;
    dx_insn = dx;
    branch_taken = br;
    md_ready = rdy;
    #1;
    dop = dx[31:27]; drd = dx[26:22]; dalu = dx[6:2];
    fop = fd[31:27]; frd = fd[26:22]; frs = fd[21:17]; frt = fd[16:12];
    is_md  = (dop == 5'd0) && (dalu == 5'd6 || dalu == 5'd7);
    lu     = (dop == 5'd8) && (drd != 5'd0) &&
             (frs == drd || (fop == 5'd0 && frt == drd) || (fop == 5'd7 && frd == drd));
    freeze = m_wait ? !rdy : (is_md && !m_done);
    squash = !m_wait && !freeze && br;
    bubble = !freeze && !squash && lu;
    exp = {!freeze && !bubble, !freeze && !bubble, !freeze, !freeze,
           squash, squash || bubble, !m_wait && freeze};
    obs = {pc_en, fd_en, dx_en, xm_en, fd_flush, dx_flush, md_start};
    obs_stall = stall_cycles;
    chk(tag, {25'd0, obs}, {25'd0, exp});
    chk({tag, "_stall"}, obs_stall, m_cnt);
    @(posedge clock);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    if (!exp[6]) m_cnt = m_cnt + 32'd1;
`endif
    if (!m_wait && freeze) begin
      m_wait = 1'b1;
    end else if (m_wait && rdy) begin
      m_wait = 1'b0;
      m_done = 1'b1;
    end else if (!m_wait) begin
      m_done = 1'b0;
    end
  endtask

  task automatic do_reset(input logic [31:0] dx);
    @(negedge clock);
    reset = 1'b0;
    dx_insn = dx;
    md_ready = 1'b0;
    #1;
    chk("rst_ctl", {25'd0, pc_en, fd_en, dx_en, xm_en, fd_flush, dx_flush, md_start}, 32'd0);
    chk("rst_stall", stall_cycles, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    chk("rst_md_start", {31'd0, md_start}, 32'd0);
    m_wait = 1'b0;
    m_done = 1'b0;
    m_cnt  = 32'h0;
  endtask

  function automatic logic [31:0] rand_insn();
    logic [4:0] r1, r2, r3;
    r1 = 5'($urandom_range(0, 3));
    r2 = 5'($urandom_range(0, 3));
    r3 = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 5))
      0: return mk(5'd0, r1, r2, r3, 5'($urandom_range(5, 8)));
      1: return mk(5'd8, r1, r2, r3, 5'd0);
      2: return mk(5'd7, r1, r2, r3, 5'd0);
      3: return mk(5'd0, r1, r2, r3, 5'd0);
      4: return mk(5'($urandom_range(0, 31)), r1, r2, r3, 5'($urandom_range(0, 31)));
      default: return 32'h0;
    endcase
  endfunction

  logic [31:0] lw_r5, lw_r0, add_dep, add_r0, mul_i, div_i;
  logic [31:0] exp_stall;

  initial begin
    lw_r5   = mk(5'd8, 5'd5, 5'd0, 5'd0, 5'd0);
    lw_r0   = mk(5'd8, 5'd0, 5'd0, 5'd0, 5'd0);
    add_dep = mk(5'd0, 5'd6, 5'd5, 5'd2, 5'd0);
    add_r0  = mk(5'd0, 5'd6, 5'd0, 5'd2, 5'd0);
    mul_i   = mk(5'd0, 5'd1, 5'd2, 5'd3, 5'd6);
    div_i   = mk(5'd0, 5'd4, 5'd2, 5'd3, 5'd7);

    do_reset(32'h0);
    step("first_run", 32'h0, 32'h0, 1'b0, 1'b0);
    chk("first_run_vec", {25'd0, obs}, {25'd0, V_NORM});

    step("lu", add_dep, lw_r5, 1'b0, 1'b0);
    chk("lu_vec", {25'd0, obs}, {25'd0, V_LU});
    step("lu_after", add_dep, 32'h0, 1'b0, 1'b0);
    chk("lu_after_vec", {25'd0, obs}, {25'd0, V_NORM});
    step("lu_r0", add_r0, lw_r0, 1'b0, 1'b0);
    chk("lu_r0_vec", {25'd0, obs}, {25'd0, V_NORM});
    step("br_lu", add_dep, lw_r5, 1'b1, 1'b0);
    chk("br_lu_vec", {25'd0, obs}, {25'd0, V_BR});

    step("mul_start", 32'h0, mul_i, 1'b0, 1'b0);
    chk("mul_start_vec", {25'd0, obs}, {25'd0, V_START});
    for (int i = 0; i < 4; i++) begin
      step("mul_wait", 32'h0, mul_i, 1'b0, 1'b0);
      chk("mul_wait_vec", {25'd0, obs}, {25'd0, V_FROZEN});
    end
    step("mul_done", 32'h0, mul_i, 1'b0, 1'b1);
    chk("mul_done_vec", {25'd0, obs}, {25'd0, V_NORM});
    step("mul_norestart", 32'h0, mul_i, 1'b0, 1'b0);
    chk("mul_norestart_vec", {25'd0, obs}, {25'd0, V_NORM});
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    exp_stall = 32'd6;
`else
    exp_stall = 32'd0;
`endif
    chk("stall_total", obs_stall, exp_stall);

    // back-to-back: mul, then div once md_done has cleared
    step("b2b_mul", 32'h0, mul_i, 1'b0, 1'b0);
    chk("b2b_mul_vec", {25'd0, obs}, {25'd0, V_START});
    step("b2b_wait", 32'h0, mul_i, 1'b0, 1'b0);
    step("b2b_mul_done", 32'h0, mul_i, 1'b0, 1'b1);
    step("b2b_gap", 32'h0, 32'h0, 1'b0, 1'b0);
    step("b2b_div", 32'h0, div_i, 1'b0, 1'b0);
    chk("b2b_div_vec", {25'd0, obs}, {25'd0, V_START});
    step("b2b_div_wait", 32'h0, div_i, 1'b0, 1'b0);

    do_reset(mul_i);
    step("post_rst", 32'h0, 32'h0, 1'b0, 1'b0);
    chk("post_rst_vec", {25'd0, obs}, {25'd0, V_NORM});

    for (int i = 0; i < 600; i++) begin
      step("rnd", rand_insn(), rand_insn(), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 2) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and stall controller that drives the enable and flush inputs of the FD, DX and XM pipeline latches and the PC register. It is the control end of the DX latch interface: it inspects the instruction leaving decode and the instruction held in DX, then decides when DX may load, when it must take a bubble, and when the whole front end freezes. It covers three cases: load-use stalls, taken-branch flushes, and multi-cycle multiply/divide waits, using a small FSM in the execute stage.

## Interface
Parameters:
- NOP_INSN, 32'h0000_0000, encoding the latches load when flushed (informative; flush is realised via latch clear).

Ports:
- clock  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- fd_insn  in  32  instruction at FD latch output.
- dx_insn  in  32  instruction at DX latch output.
- branch_taken  in  1  execute stage resolved a taken branch/jump this cycle.
- md_ready  in  1  multdiv result valid (single-cycle pulse).
- pc_en  out  1  PC register enable.
- fd_en  out  1  FD latch enable.
- dx_en  out  1  DX latch enable.
- xm_en  out  1  XM latch enable.
- fd_flush  out  1  clear FD latch at next edge.
- dx_flush  out  1  clear DX latch at next edge (bubble).
- md_start  out  1  one-cycle start pulse to multdiv.
- stall_cycles  out  32  stall counter (see Configuration).

## Operation
- Fields: opcode [31:27], rd [26:22], rs [21:17], rt [16:12], ALU op [6:2].
- dx_is_md: dx opcode 5'b00000 and ALU op 5'b00110 (mul) or 5'b00111 (div).
- load_use: dx opcode 5'b01000 (lw), dx.rd != 0, and any of: fd.rs == dx.rd; fd opcode 5'b00000 and fd.rt == dx.rd; fd opcode 5'b00111 (sw) and fd.rd == dx.rd.
- FSM states: RUN, MD_WAIT.
- RUN, dx_is_md: md_start=1; pc_en=fd_en=dx_en=xm_en=0; next MD_WAIT.
- RUN, branch_taken: all enables 1; fd_flush=dx_flush=1; next RUN.
- RUN, load_use: pc_en=fd_en=0; dx_en=1; dx_flush=1; xm_en=1; next RUN.
- RUN, otherwise: all enables 1, flushes 0.
- MD_WAIT, md_ready=0: all enables 0, md_start 0; stay.
- MD_WAIT, md_ready=1: all enables 1; next RUN. Priority: a load_use raised by the next instruction is evaluated normally in this cycle.
- Priority in RUN: dx_is_md > branch_taken > load_use. mul/div never branches, so the first two never conflict in legal code. Branch overrides load_use because the stalled FD instruction is squashed.
- After MD_WAIT exits, the latched mul/div in DX advances. It must not restart: track a 1-bit md_done flag, set on exit and cleared when dx_en is active in RUN. While set, dx_is_md is ignored.

## Timing
- Reset asserted: state RUN, md_done 0, all enables 0, flushes 0, md_start 0, stall_cycles 0. The FSM returns to RUN immediately even mid-MD_WAIT.
- First edge after reset release: normal RUN outputs.
- Outputs are combinational from state, md_done and inputs, with no registered latency. The state update takes effect at the next rising edge.
- Load-use costs exactly 1 bubble cycle. A branch costs 2 squashed slots.
- A mul/div costs N+1 frozen cycles, where N is the number of cycles from md_start to md_ready. The start cycle is frozen too.
- md_ready arriving in the md_start cycle is ignored. multdiv guarantees N ≥ 1.

## Configuration
- PIPE_HAZARD_CTRL_PERF_EN defined: stall_cycles increments by 1 at every edge where pc_en==0 and reset is deasserted. It wraps at 2^32−1 → 0.
- Undefined: the counter is not built and stall_cycles is tied to 32'h0.

## Test plan
- Reset: hold reset=0 mid-MD_WAIT, then release → all enables 0 during reset, then 1 on the first edge in RUN; md_start never pulses.
- Load-use: dx_insn=lw r5, fd_insn=add r6,r5,r2 → one cycle of pc_en=fd_en=0, dx_flush=1, then normal. Repeat with dx.rd=r0 → no stall.
- Branch: branch_taken=1 with load_use also true → fd_flush=dx_flush=1, pc_en=1, no stall.
- Multdiv: dx_insn=mul, md_ready after 4 cycles → md_start pulses once, 5 frozen cycles, xm_en=1 on the md_ready cycle, and no second md_start.
- Back-to-back: mul followed by div → two separate md_start pulses, with md_done clearing between them.
- Counter (PERF_EN on): one load-use plus one 4-cycle mul → stall_cycles=6. With PERF_EN off, stall_cycles stays 0.
